// File: rtl/flex_bit_timer.sv
// Runtime-configurable bit timer: one shift_strobe per bit period, packet_done on the
// last bit, a single packet per enable assertion, and abort when enable drops.
module flex_bit_timer #(
    parameter int CNT_WIDTH  = 8,
    parameter int IDX_WIDTH  = 4,
    parameter int MID_SAMPLE = 0
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 enable_timer,
    input  logic [CNT_WIDTH-1:0] bit_period,
    input  logic [IDX_WIDTH-1:0] num_bits,
    output logic                 shift_strobe,
    output logic                 packet_done,
    output logic                 busy,
    output logic [IDX_WIDTH-1:0] bit_index,
    output logic                 cfg_err
);

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t               state_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] period_q;
    logic [IDX_WIDTH-1:0] nbits_q;
    logic                 first_q;
    logic                 strobe_q;
    logic                 done_q;
    logic                 busy_q;
    logic [IDX_WIDTH-1:0] idx_q;
    logic                 err_q;

    logic [CNT_WIDTH-1:0] cnt_d;
    logic [CNT_WIDTH-1:0] first_off;
    logic [CNT_WIDTH-1:0] target;
    logic [IDX_WIDTH-1:0] idx_d;
    logic                 hit;
    logic                 last_bit;
    logic                 cfg_ok;

    // cnt_q holds cycles elapsed minus one since the last strobe (or start), so the
    // strobe fires on the edge where the incremented count reaches the target.
    assign cnt_d     = cnt_q + CNT_WIDTH'(1);
    assign first_off = (MID_SAMPLE != 0) ? (period_q >> 1) : period_q;
    assign target    = first_q ? first_off : period_q;
    assign hit       = (cnt_d == target);
    assign idx_d     = idx_q + IDX_WIDTH'(1);
    assign last_bit  = (idx_d == nbits_q);
    assign cfg_ok    = (bit_period >= CNT_WIDTH'(2)) && (num_bits != '0);

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            period_q <= '0;
            nbits_q  <= '0;
            first_q  <= 1'b0;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            idx_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    idx_q <= '0;
                    if (enable_timer) begin
                        if (cfg_ok) begin
                            state_q  <= RUN;
                            busy_q   <= 1'b1;
                            period_q <= bit_period;
                            nbits_q  <= num_bits;
                            first_q  <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    // Abort wins over a coinciding strobe edge.
                    if (!enable_timer) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                        idx_q   <= '0;
                    end else if (done_q) begin
                        state_q <= HOLD;
                        busy_q  <= 1'b0;
                    end else if (hit) begin
                        strobe_q <= 1'b1;
                        done_q   <= last_bit;
                        idx_q    <= idx_d;
                        cnt_q    <= '0;
                        first_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                HOLD: begin
                    if (!enable_timer) begin
                        state_q <= IDLE;
                        idx_q   <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign shift_strobe = strobe_q;
    assign packet_done  = done_q;
    assign busy         = busy_q;
    assign bit_index    = idx_q;
    assign cfg_err      = err_q;

endmodule

// File: tb/tb_flex_bit_timer.sv
// Bench for flex_bit_timer: two instances (full-period and mid-bit first sample) share
// stimulus and are checked every cycle against an arithmetic model of strobe times.
module tb_flex_bit_timer;

    logic       clk;
    logic       n_rst;
    logic       enable_timer;
    logic [7:0] bit_period;
    logic [3:0] num_bits;
    logic [1:0] sst, pdn, bsy, cerr;
    logic [3:0] bidx0, bidx1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_e = 0;
    bit model_on = 0;

    // model state: 0 idle, 1 running, 2 holding
    int m_mode[2];
    int m_t0[2];
    int m_p[2];
    int m_n[2];
    bit e_str[2];
    bit e_done[2];
    bit e_busy[2];
    int e_idx[2];
    bit e_err[2];

    int a0_q[$], a1_q[$], d0_q[$], d1_q[$];
    int err_cnt0;

    flex_bit_timer #(.CNT_WIDTH(8), .IDX_WIDTH(4), .MID_SAMPLE(0)) u0 (
        .clk(clk), .n_rst(n_rst), .enable_timer(enable_timer),
        .bit_period(bit_period), .num_bits(num_bits),
        .shift_strobe(sst[0]), .packet_done(pdn[0]), .busy(bsy[0]),
        .bit_index(bidx0), .cfg_err(cerr[0]));

    flex_bit_timer #(.CNT_WIDTH(8), .IDX_WIDTH(4), .MID_SAMPLE(1)) u1 (
        .clk(clk), .n_rst(n_rst), .enable_timer(enable_timer),
        .bit_period(bit_period), .num_bits(num_bits),
        .shift_strobe(sst[1]), .packet_done(pdn[1]), .busy(bsy[1]),
        .bit_index(bidx1), .cfg_err(cerr[1]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Strobe k lands on edge start + F + (k-1)*P; bit_index counts strobes so far.
    task automatic model_step();
        bit prev_done;
        int el, f, k;
        for (int i = 0; i < 2; i++) begin
            if (!n_rst) begin
                m_mode[i] = 0;
                e_str[i] = 0; e_done[i] = 0; e_busy[i] = 0; e_idx[i] = 0; e_err[i] = 0;
            end else begin
                prev_done = e_done[i];
                e_str[i] = 0; e_done[i] = 0; e_err[i] = 0;
                case (m_mode[i])
                    0: begin
                        e_idx[i] = 0;
                        e_busy[i] = 0;
                        if (enable_timer) begin
                            if (bit_period < 2 || num_bits == 0) begin
                                e_err[i] = 1;
                            end else begin
                                m_mode[i] = 1;
                                m_t0[i] = cyc;
                                m_p[i] = int'(bit_period);
                                m_n[i] = int'(num_bits);
                                e_busy[i] = 1;
                            end
                        end
                    end
                    1: begin
                        if (!enable_timer) begin
                            m_mode[i] = 0; e_busy[i] = 0; e_idx[i] = 0;
                        end else if (prev_done) begin
                            m_mode[i] = 2; e_busy[i] = 0;
                        end else begin
                            el = cyc - m_t0[i];
                            f = (i == 1) ? m_p[i] / 2 : m_p[i];
                            if (el >= f && (el - f) % m_p[i] == 0) begin
                                k = (el - f) / m_p[i] + 1;
                                e_str[i] = 1;
                                e_idx[i] = k;
                                e_done[i] = (k == m_n[i]);
                            end
                        end
                    end
                    default: begin
                        e_busy[i] = 0;
                        if (!enable_timer) begin
                            m_mode[i] = 0; e_idx[i] = 0;
                        end
                    end
                endcase
            end
        end
        if (!n_rst) model_on = 1;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (model_on) begin
                chk("strobe0", int'(sst[0]), int'(e_str[0]));
                chk("done0",   int'(pdn[0]), int'(e_done[0]));
                chk("busy0",   int'(bsy[0]), int'(e_busy[0]));
                chk("index0",  int'(bidx0),  e_idx[0]);
                chk("cfgerr0", int'(cerr[0]), int'(e_err[0]));
                chk("strobe1", int'(sst[1]), int'(e_str[1]));
                chk("done1",   int'(pdn[1]), int'(e_done[1]));
                chk("busy1",   int'(bsy[1]), int'(e_busy[1]));
                chk("index1",  int'(bidx1),  e_idx[1]);
                chk("cfgerr1", int'(cerr[1]), int'(e_err[1]));
                if (sst[0]) a0_q.push_back(cyc - start_e);
                if (sst[1]) a1_q.push_back(cyc - start_e);
                if (pdn[0]) d0_q.push_back(cyc - start_e);
                if (pdn[1]) d1_q.push_back(cyc - start_e);
                if (cerr[0]) err_cnt0++;
            end
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        a0_q.delete(); a1_q.delete(); d0_q.delete(); d1_q.delete();
        err_cnt0 = 0;
    endtask

    task automatic start_packet(input int p, input int n);
        clear_logs();
        bit_period = 8'(p);
        num_bits = 4'(n);
        start_e = cyc + 1;
        enable_timer = 1'b1;
    endtask

    // which: 0/1 strobe offsets of u0/u1, 2/3 done offsets of u0/u1
    task automatic check_seq(input string name, input int which, input int first,
                             input int stride, input int count);
        logic [31:0] exp_q[$];
        int got[$];
        case (which)
            0: got = a0_q;
            1: got = a1_q;
            2: got = d0_q;
            default: got = d1_q;
        endcase
        for (int k = 0; k < count; k++) exp_q.push_back(32'(first + stride * k));
        chk({name, "_len"}, got.size(), exp_q.size());
        for (int k = 0; k < count && k < got.size(); k++)
            chk({name, "_at"}, got[k], int'(exp_q[k]));
    endtask

    task automatic end_packet();
        enable_timer = 1'b0;
        step(2);
    endtask

    initial begin
        n_rst = 1'b0;
        enable_timer = 1'b0;
        bit_period = 8'd10;
        num_bits = 4'd9;
        step(3);
        chk("reset_busy", int'(bsy), 0);
        chk("reset_strobe", int'(sst), 0);
        chk("reset_index", int'(bidx0) + int'(bidx1), 0);
        n_rst = 1'b1;
        step(2);

        // P=10 N=9: strobes at 10..90 (full) and 5..85 (mid-bit)
        start_packet(10, 9);
        step(100);
        check_seq("p10_strobes0", 0, 10, 10, 9);
        check_seq("p10_done0", 2, 90, 0, 1);
        check_seq("p10_strobes1", 1, 5, 10, 9);
        check_seq("p10_done1", 3, 85, 0, 1);
        chk("hold_index", int'(bidx0), 9);
        chk("hold_busy", int'(bsy[0]), 0);
        end_packet();
        chk("rearm_index", int'(bidx0), 0);

        // P=16 N=10 with a mid-packet period change that must be ignored
        start_packet(16, 10);
        step(20);
        bit_period = 8'd4;
        step(150);
        check_seq("p16_strobes1", 1, 8, 16, 10);
        check_seq("p16_done1", 3, 152, 0, 1);
        check_seq("p16_strobes0", 0, 16, 16, 10);
        end_packet();

        // Abort on strobe 3's edge, restart one cycle later
        start_packet(10, 9);
        step(30);
        enable_timer = 1'b0;
        step(1);
        chk("abort_busy", int'(bsy[0]), 0);
        chk("abort_index", int'(bidx0), 0);
        check_seq("abort_strobes0", 0, 10, 10, 2);
        check_seq("abort_strobes1", 1, 5, 10, 3);
        start_packet(10, 9);
        step(100);
        check_seq("restart_strobes0", 0, 10, 10, 9);
        end_packet();

        // Illegal configs held for three edges
        start_packet(1, 5);
        step(3);
        enable_timer = 1'b0;
        step(2);
        chk("illegal_p_errs", err_cnt0, 3);
        check_seq("illegal_p_strobes", 0, 0, 0, 0);
        start_packet(10, 0);
        step(3);
        enable_timer = 1'b0;
        step(2);
        chk("illegal_n_errs", err_cnt0, 3);
        check_seq("illegal_n_strobes", 0, 0, 0, 0);

        // Boundaries: widest period/longest packet, then shortest
        start_packet(255, 15);
        step(3840);
        check_seq("p255_strobes0", 0, 255, 255, 15);
        check_seq("p255_done0", 2, 3825, 0, 1);
        check_seq("p255_done1", 3, 3697, 0, 1);
        end_packet();
        start_packet(2, 1);
        step(5);
        check_seq("p2_strobes1", 1, 1, 0, 1);
        check_seq("p2_done1", 3, 1, 0, 1);
        check_seq("p2_done0", 2, 2, 0, 1);
        end_packet();

        // Reset mid-packet with enable still high
        start_packet(10, 9);
        step(25);
        n_rst = 1'b0;
        step(1);
        chk("midreset_busy", int'(bsy), 0);
        chk("midreset_index", int'(bidx0), 0);
        clear_logs();
        n_rst = 1'b1;
        start_e = cyc + 1;
        step(1);
        chk("postreset_busy", int'(bsy[0]), 1);
        step(94);
        check_seq("postreset_strobes0", 0, 10, 10, 9);
        end_packet();

        // Randomised traffic, including illegal configs, aborts and resets
        for (int it = 0; it < 400; it++) begin
            int hi_len;
            bit_period = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 1))
                                                     : 8'($urandom_range(2, 24));
            num_bits = 4'($urandom_range(0, 15));
            enable_timer = 1'b1;
            hi_len = $urandom_range(1, 150);
            for (int c = 0; c < hi_len; c++) begin
                step(1);
                if ($urandom_range(0, 40) == 0) bit_period = 8'($urandom_range(0, 30));
                if ($urandom_range(0, 40) == 0) num_bits = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 400) == 0) begin
                    n_rst = 1'b0;
                    step($urandom_range(1, 2));
                    n_rst = 1'b1;
                end
            end
            enable_timer = 1'b0;
            step($urandom_range(1, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/flex_bit_timer.md
Name: flex_bit_timer

Overview:
- Parametrised, runtime-configurable bit timer for the serial receive path.
- Generates one `shift_strobe` per bit period and a `packet_done` pulse on the last bit of a packet.
- Bit period and bits-per-packet are input ports, not constants, so one block serves every baud rate and frame format.
- Adds the following:
  - optional mid-bit first sample
  - config latching
  - busy/bit-index status
  - abort on enable drop
  - illegal-config flag
  - single-packet-per-enable handshake

Parameters:
- CNT_WIDTH, 8, width of bit-period counter and `bit_period` port; legal periods 2..2^CNT_WIDTH-1.
- IDX_WIDTH, 4, width of bit counter, `num_bits` and `bit_index`; legal packets 1..2^IDX_WIDTH-1 bits.
- MID_SAMPLE, 0, 0 = first strobe one full period after start; 1 = first strobe floor(P/2) cycles after start.

Ports:
- `clk`  input  1  system clock, rising edge.
- `n_rst`  input  1  reset, synchronous, active-low.
- `enable_timer`  input  1  level; high starts/continues a packet, low aborts/re-arms.
- `bit_period`  input  CNT_WIDTH  P, clock cycles per bit; sampled only at packet start.
- `num_bits`  input  IDX_WIDTH  N, strobes per packet; sampled only at packet start.
- `shift_strobe`  output  1  one-cycle pulse per bit.
- `packet_done`  output  1  one-cycle pulse, coincident with the Nth strobe.
- `busy`  output  1  high while in RUN.
- `bit_index`  output  IDX_WIDTH  strobes issued so far this packet (0..N).
- `cfg_err`  output  1  one-cycle pulse when a start is refused for illegal config.

Behaviour:
- Reset: synchronous, active-low, sampled on `clk` rising edge. While `n_rst`=0 at an edge, the following clear: state to IDLE; counters, latched config, and all outputs to 0. Reset overrides every other event, including mid-packet.
- All outputs are registered; no combinational path from inputs to outputs.
- States: IDLE, RUN, HOLD.
- IDLE, `enable_timer`=1 at edge E:
  - P<2 or N=0: set `cfg_err`=1 for cycle E..E+1; stay IDLE; re-evaluate every cycle `enable_timer` stays high (`cfg_err` repeats).
  - Otherwise:
    - latch P and N;
    - clear the cycle counter and `bit_index`;
    - go to RUN; `busy`=1 from E.
    - Later changes to `bit_period`/`num_bits` have no effect until the next start.
- RUN, strobe timing:
  - First offset F = P (MID_SAMPLE=0) or floor(P/2) (MID_SAMPLE=1).
  - Strobe k (k=1..N) is high during the cycle following edge E+F+(k-1)*P, for exactly one cycle.
  - `bit_index` increments in the same cycle as each strobe.
- Last bit: on strobe N, `packet_done`=1 in the same cycle; at the next edge go to HOLD, `busy`=0, `bit_index` holds N.
- HOLD: wait for `enable_timer`=0, then go to IDLE and clear `bit_index` to 0. No strobes are issued in HOLD, so one enable pulse gives exactly one packet.
- Abort: `enable_timer`=0 sampled in RUN goes to IDLE at that edge. In the same cycle, the cycle counter and `bit_index` clear, and no strobe or `packet_done` is issued from that edge, even if it coincides with a strobe edge.
- Restart: from IDLE, `enable_timer` high one cycle after an abort starts a fresh packet with new config.
- Arithmetic:
  - The cycle counter is unsigned CNT_WIDTH, counting 1..P and wrapping to 1 on each strobe; it never overflows because P ≤ 2^CNT_WIDTH-1.
  - `bit_index` never exceeds N.
- Edge cases:
  - P=2, MID_SAMPLE=1 gives F=1; strobes are separated by exactly one low cycle.
  - N=1 gives `packet_done` on the first strobe.

Test Plan:
- Reset: `n_rst`=0 during RUN with P=10, N=9 → at the next edge all outputs 0 and state IDLE; with `enable_timer` still high after release → a new packet starts on the first released edge.
- MID_SAMPLE=0, P=10, N=9, enable rises at edge E, held high:
  - `shift_strobe` high after edges E+10, E+20, …, E+90 (9 pulses);
  - `packet_done` only after E+90;
  - `bit_index` 1..9;
  - no further strobes while enable stays high; `bit_index` returns to 0 after enable drops.
- MID_SAMPLE=1, P=16, N=10: first strobe after E+8, then E+24, …, E+152 with `packet_done`; change `bit_period` to 4 mid-packet → spacing stays 16.
- Abort: P=10, N=9, drop enable at edge E+30 (strobe 3's edge) → no strobe 3, `busy`/`bit_index` 0 next cycle; re-enable at E+31 → first strobe at E+41.
- Illegal config: P=1 or N=0 with enable high 3 cycles → `cfg_err` high 3 cycles, `busy` stays 0, no strobes.
- Boundary: P=255 (CNT_WIDTH=8), N=15, MID_SAMPLE=0 → strobes every 255 cycles, `packet_done` after E+3825; and P=2, N=1, MID_SAMPLE=1 → strobe and `packet_done` after E+1.
